// File: rtl/feedback_dac_writer.sv
// -----------------------------------------------------------------------------
// feedback_dac_writer
//
// Consumer end of the feedback controller's output stream. Each valid signed
// sample is latched into a single-entry pending register. When the writer is
// idle and enabled, the pending sample is serialised to the trap-power DAC over
// a 3-wire SPI link (CS_n, SCLK, MOSI, MSB first). LDAC_n is then pulsed to load
// the DAC output. A newer sample overwrites an untaken pending sample, so the
// latest value wins.
//
// Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> LOAD -> IDLE.
// Frame length is CS_SETUP_CYCLES + 2*SCLK_DIV*DATA_WIDTH + CS_HOLD_CYCLES +
// LDAC_CYCLES clk cycles. At least one IDLE cycle separates two frames.
//
// Ports
//   clk            system clock (sole domain)
//   reset          asynchronous reset, active low
//   sample         signed feedback value
//   sample_valid   1-cycle strobe; sample is captured on this cycle
//   enable         1: frames may start; 0: no new frame starts
//   dac_cs_n       SPI chip select, active low
//   dac_sclk       SPI clock, idles low; the DAC samples on the rising edge
//   dac_mosi       serial data, MSB first
//   dac_ldac_n     DAC load strobe, active low
//   busy           1 whenever the FSM is not idle
//   sample_dropped 1-cycle pulse: an untaken pending sample was overwritten
//   update_done    1-cycle pulse on the last LDAC_n-low cycle
// -----------------------------------------------------------------------------
module feedback_dac_writer #(
   parameter int DATA_WIDTH      = 16,
   parameter int SCLK_DIV        = 4,
   parameter int CS_SETUP_CYCLES = 2,
   parameter int CS_HOLD_CYCLES  = 2,
   parameter int LDAC_CYCLES     = 2,
   parameter bit TWOS_TO_OFFSET  = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] sample,
   input  logic                         sample_valid,
   input  logic                         enable,
   output logic                         dac_cs_n,
   output logic                         dac_sclk,
   output logic                         dac_mosi,
   output logic                         dac_ldac_n,
   output logic                         busy,
   output logic                         sample_dropped,
   output logic                         update_done
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One phase counter serves SETUP, the SCLK half-periods, HOLD and LOAD,
   // so it is sized for the largest of those counts.
   localparam int MAX_CNT = max2(max2(CS_SETUP_CYCLES, SCLK_DIV),
                                 max2(CS_HOLD_CYCLES, LDAC_CYCLES));
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int BIT_W   = $clog2(DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LDAC_LAST  = CNT_W'(LDAC_CYCLES - 1);
   // Count value one cycle before the last LOAD cycle (only meaningful when
   // LDAC_CYCLES > 1; with a single LOAD cycle the pulse is raised on HOLD exit).
   localparam logic [CNT_W-1:0] LDAC_DONE  = CNT_W'((LDAC_CYCLES > 1) ? LDAC_CYCLES - 2 : 0);
   localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

   // Inverting the MSB maps two's complement onto offset binary.
   localparam logic [DATA_WIDTH-1:0] MSB_FLIP =
      TWOS_TO_OFFSET ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_LOAD
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] rest;        // bits still to send, left-aligned
   logic                  pending;
   logic [DATA_WIDTH-1:0] pend_data;
   logic                  take;
   logic [DATA_WIDTH-1:0] word_in;

   assign take    = (state == S_IDLE) && pending && enable;
   assign word_in = pend_data ^ MSB_FLIP;

   // Pending register. A take and a new valid on the same edge hand the old
   // value to the FSM and keep the new one, so nothing is lost.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before this edge.
      if (!reset) begin
         pending        <= 1'b0;
         // NOTE: the data register is reset as well. It is a single word, and
         // a known value keeps the MOSI word deterministic after reset.
         pend_data      <= '0;
         sample_dropped <= 1'b0;
      end else begin
         sample_dropped <= 1'b0;
         if (sample_valid) begin
            pend_data      <= sample;
            pending        <= 1'b1;
            sample_dropped <= pending && !take;
         end else if (take) begin
            pending <= 1'b0;
         end
      end
   end

   // Frame FSM. All outputs are registered and change only on state steps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         rest        <= '0;
         dac_cs_n    <= 1'b1;
         dac_sclk    <= 1'b0;
         dac_mosi    <= 1'b0;
         dac_ldac_n  <= 1'b1;
         busy        <= 1'b0;
         update_done <= 1'b0;
      end else begin
         update_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (take) begin
                  state    <= S_SETUP;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  dac_cs_n <= 1'b0;
                  dac_mosi <= word_in[DATA_WIDTH-1];
                  rest     <= word_in << 1;
               end
            end

            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state   <= S_SHIFT;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            // Each bit is a low half-period followed by a high half-period.
            // MOSI only moves when SCLK falls, so it is stable across the rise.
            S_SHIFT: begin
               if (cnt != DIV_LAST) begin
                  cnt <= cnt + CNT_ONE;
               end else begin
                  cnt <= '0;
                  if (!dac_sclk) begin
                     dac_sclk <= 1'b1;
                  end else begin
                     dac_sclk <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= S_HOLD;
                     end else begin
                        bit_cnt  <= bit_cnt + BIT_ONE;
                        dac_mosi <= rest[DATA_WIDTH-1];
                        rest     <= rest << 1;
                     end
                  end
               end
            end

            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state       <= S_LOAD;
                  cnt         <= '0;
                  dac_cs_n    <= 1'b1;
                  dac_mosi    <= 1'b0;
                  dac_ldac_n  <= 1'b0;
                  update_done <= (LDAC_CYCLES == 1);
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            S_LOAD: begin
               if (cnt == LDAC_LAST) begin
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  cnt        <= '0;
                  dac_ldac_n <= 1'b1;
               end else begin
                  cnt         <= cnt + CNT_ONE;
                  update_done <= (LDAC_CYCLES > 1) && (cnt == LDAC_DONE);
               end
            end

            default: begin
               state      <= S_IDLE;
               busy       <= 1'b0;
               cnt        <= '0;
               dac_cs_n   <= 1'b1;
               dac_sclk   <= 1'b0;
               dac_mosi   <= 1'b0;
               dac_ldac_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_feedback_dac_writer.sv
// -----------------------------------------------------------------------------
// tb_feedback_dac_writer
//
// Self-checking bench for feedback_dac_writer. The main instance uses default
// parameters. A second instance shares the inputs and uses minimal timing
// (SCLK_DIV=1, one-cycle setup/hold/load) with two's complement pass-through.
// Negedge monitors rebuild the SPI words and record frame timing from the pins.
// -----------------------------------------------------------------------------
module tb_feedback_dac_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sample = '0;
   logic        sample_valid = 1'b0;
   logic        enable = 1'b1;

   logic dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n, busy, sample_dropped, update_done;
   logic raw_cs_n, raw_sclk, raw_mosi, raw_ldac_n, raw_busy, raw_dropped, raw_done;

   always #5 clk = ~clk;

   feedback_dac_writer u_dut (
      .clk            (clk),
      .reset          (reset),
      .sample         (sample),
      .sample_valid   (sample_valid),
      .enable         (enable),
      .dac_cs_n       (dac_cs_n),
      .dac_sclk       (dac_sclk),
      .dac_mosi       (dac_mosi),
      .dac_ldac_n     (dac_ldac_n),
      .busy           (busy),
      .sample_dropped (sample_dropped),
      .update_done    (update_done)
   );

   feedback_dac_writer #(
      .SCLK_DIV        (1),
      .CS_SETUP_CYCLES (1),
      .CS_HOLD_CYCLES  (1),
      .LDAC_CYCLES     (1),
      .TWOS_TO_OFFSET  (1'b0)
   ) u_dut_raw (
      .clk            (clk),
      .reset          (reset),
      .sample         (sample),
      .sample_valid   (sample_valid),
      .enable         (enable),
      .dac_cs_n       (raw_cs_n),
      .dac_sclk       (raw_sclk),
      .dac_mosi       (raw_mosi),
      .dac_ldac_n     (raw_ldac_n),
      .busy           (raw_busy),
      .sample_dropped (raw_dropped),
      .update_done    (raw_done)
   );

   // ---------------- posedge bookkeeping: input event stamps ----------------
   int   pc = 0;
   int   valid_pc = 0;
   int   en_pc = 0;
   logic prev_en = 1'b1;

   always @(posedge clk) begin
      pc      <= pc + 1;
      prev_en <= enable;
      if (sample_valid) valid_pc <= pc;
      if (enable && !prev_en) en_pc <= pc;
   end

   // ---------------- main instance pin monitor ----------------
   logic        p_sclk = 1'b0, p_cs = 1'b1, p_ldac = 1'b1, p_mosi = 1'b0;
   logic [15:0] cur_word = '0;
   int          cur_bits = 0;
   logic [15:0] words [64];
   int          word_bits [64];
   int          n_words = 0;
   int          rises = 0, cs_low = 0, last_cs_low = 0;
   int          ldac_low = 0, last_ldac_low = 0, ldac_pulses = 0;
   int          fall_pc = 0, cs_rise_pc = 0, ldac_fall_pc = 0;
   int          n_upd = 0, n_drop = 0, mosi_viol = 0;

   always @(negedge clk) begin
      p_sclk <= dac_sclk;
      p_cs   <= dac_cs_n;
      p_ldac <= dac_ldac_n;
      p_mosi <= dac_mosi;
      if (dac_sclk && !p_sclk) begin
         rises    <= rises + 1;
         cur_word <= {cur_word[14:0], dac_mosi};
         cur_bits <= cur_bits + 1;
      end
      if (dac_sclk && p_sclk && (dac_mosi != p_mosi)) mosi_viol <= mosi_viol + 1;
      if (!dac_cs_n && p_cs) begin
         fall_pc  <= pc;
         cur_word <= '0;
         cur_bits <= 0;
         cs_low   <= 1;
      end else if (!dac_cs_n) begin
         cs_low <= cs_low + 1;
      end
      if (dac_cs_n && !p_cs) begin
         last_cs_low          <= cs_low;
         words[n_words % 64]     <= cur_word;
         word_bits[n_words % 64] <= cur_bits;
         n_words              <= n_words + 1;
         cs_rise_pc           <= pc;
      end
      if (!dac_ldac_n && p_ldac) begin
         ldac_fall_pc <= pc;
         ldac_low     <= 1;
         ldac_pulses  <= ldac_pulses + 1;
      end else if (!dac_ldac_n) begin
         ldac_low <= ldac_low + 1;
      end
      if (dac_ldac_n && !p_ldac) last_ldac_low <= ldac_low;
      if (update_done) n_upd <= n_upd + 1;
      if (sample_dropped) n_drop <= n_drop + 1;
   end

   // ---------------- pass-through instance monitor ----------------
   logic        r_p_sclk = 1'b0, r_p_cs = 1'b1;
   logic [15:0] r_cur = '0, r_last = '0;
   int          r_upd = 0;

   always @(negedge clk) begin
      r_p_sclk <= raw_sclk;
      r_p_cs   <= raw_cs_n;
      if (raw_sclk && !r_p_sclk) r_cur <= {r_cur[14:0], raw_mosi};
      if (!raw_cs_n && r_p_cs) r_cur <= '0;
      if (raw_cs_n && !r_p_cs) r_last <= r_cur;
      if (raw_done) r_upd <= r_upd + 1;
   end

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] v);
      @(negedge clk);
      sample       = v;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // Waits until the main instance has finished `target` frames and both
   // instances are idle; an expired budget counts as a failure.
   task automatic wait_done(input int target, input string name);
      bit ok = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (n_words >= target && !busy && !raw_busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s: timeout, frames seen %0d expected %0d", name, n_words, target);
      end
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] smp;
      logic [15:0] exp_off;
      logic [15:0] exp_raw;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w0, u0, r0, p0, d0, ri0;

      vecs[0] = '{16'h0000, 16'h8000, 16'h0000};
      vecs[1] = '{16'h7FFF, 16'hFFFF, 16'h7FFF};
      vecs[2] = '{16'h8000, 16'h0000, 16'h8000};
      vecs[3] = '{16'h1234, 16'h9234, 16'h1234};
      vecs[4] = '{16'hA5C3, 16'h25C3, 16'hA5C3};

      // ---------------- reset state ----------------
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs_n",    dac_cs_n,       1);
      check("rst_sclk",    dac_sclk,       0);
      check("rst_mosi",    dac_mosi,       0);
      check("rst_ldac_n",  dac_ldac_n,     1);
      check("rst_busy",    busy,           0);
      check("rst_dropped", sample_dropped, 0);
      check("rst_done",    update_done,    0);
      check("rst_raw_cs",  raw_cs_n,       1);
      check("rst_raw_ldac", raw_ldac_n,    1);
      check("rst_raw_drop", raw_dropped,   0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // ---------------- T1: word encoding ----------------
      for (int i = 0; i < 5; i++) begin
         w0 = n_words;
         r0 = r_upd;
         send(vecs[i].smp);
         wait_done(w0 + 1, "t1_wait");
         check("t1_word",     words[w0 % 64],     vecs[i].exp_off);
         check("t1_bits",     word_bits[w0 % 64], 16);
         check("t1_raw_word", r_last,             vecs[i].exp_raw);
         check("t1_raw_upd",  r_upd - r0,         1);
      end

      // ---------------- T2: frame timing ----------------
      w0 = n_words; u0 = n_upd; p0 = ldac_pulses; d0 = n_drop; ri0 = rises;
      send(16'h4321);
      wait_done(w0 + 1, "t2_wait");
      check("t2_word",       words[w0 % 64],           16'hC321);
      check("t2_rises",      rises - ri0,              16);
      check("t2_cs_low",     last_cs_low,              132);
      check("t2_ldac_low",   last_ldac_low,            2);
      check("t2_ldac_gap",   ldac_fall_pc - cs_rise_pc, 0);
      check("t2_latency",    fall_pc - valid_pc,       2);
      check("t2_upd",        n_upd - u0,               1);
      check("t2_ldac_pulse", ldac_pulses - p0,         1);
      check("t2_no_drop",    n_drop - d0,              0);
      check("t2_mosi_stable", mosi_viol,               0);

      // ---------------- T3: latest value wins ----------------
      w0 = n_words; p0 = ldac_pulses; d0 = n_drop;
      send(16'h1111);
      repeat (8) @(negedge clk);
      send(16'h2222);
      repeat (8) @(negedge clk);
      send(16'h3333);
      wait_done(w0 + 2, "t3_wait");
      check("t3_drop",    n_drop - d0,            1);
      check("t3_pulses",  ldac_pulses - p0,       2);
      check("t3_word_a",  words[w0 % 64],         16'h9111);
      check("t3_word_c",  words[(w0 + 1) % 64],   16'hB333);

      // ---------------- T4: enable gating ----------------
      @(negedge clk);
      enable = 1'b0;
      w0 = n_words; ri0 = rises;
      send(16'h1234);
      repeat (20) @(negedge clk);
      check("t4_idle_busy",  busy,         0);
      check("t4_idle_cs",    dac_cs_n,     1);
      check("t4_idle_rises", rises - ri0,  0);
      @(negedge clk);
      enable = 1'b1;
      wait_done(w0 + 1, "t4_wait");
      check("t4_en_latency", fall_pc - en_pc, 1);
      check("t4_word",       words[w0 % 64],  16'h9234);

      // ---------------- T5: reset mid-frame ----------------
      send(16'h5555);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!dac_cs_n) break;
      end
      send(16'h0F0F);
      repeat (56) @(negedge clk);
      p0 = ldac_pulses; u0 = n_upd;
      #2 reset = 1'b0;
      #1;
      check("t5_cs_n",   dac_cs_n,   1);
      check("t5_sclk",   dac_sclk,   0);
      check("t5_ldac_n", dac_ldac_n, 1);
      check("t5_busy",   busy,       0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ri0 = rises;
      repeat (300) @(negedge clk);
      check("t5_no_rises",  rises - ri0,      0);
      check("t5_no_ldac",   ldac_pulses - p0, 0);
      check("t5_no_upd",    n_upd - u0,       0);
      check("t5_idle_busy", busy,             0);
      w0 = n_words;
      send(16'h00FF);
      wait_done(w0 + 1, "t5_wait");
      check("t5_word_after", words[w0 % 64], 16'h80FF);

      // ---------------- T6: valid on the take edge ----------------
      w0 = n_words; p0 = ldac_pulses; d0 = n_drop;
      @(negedge clk);
      sample       = 16'hAAAA;
      sample_valid = 1'b1;
      @(negedge clk);
      sample       = 16'h0001;
      @(negedge clk);
      sample_valid = 1'b0;
      wait_done(w0 + 2, "t6_wait");
      check("t6_no_drop", n_drop - d0,          0);
      check("t6_pulses",  ldac_pulses - p0,     2);
      check("t6_word_a",  words[w0 % 64],       16'h2AAA);
      check("t6_word_b",  words[(w0 + 1) % 64], 16'h8001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
